// File: rtl/mdio_pkg.sv
// MDIO master shared definitions: FSM states, Clause-22 frame fields, frame builder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdio_pkg;

  typedef enum logic [2:0] {
    PHY_RST,
    PHY_WAIT,
    IDLE,
    SHIFT,
    RESP
  } state_t;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;
  localparam int         FRAME_BITS = 64;
  localparam int         PRE_BITS   = 32;

  // Frame bit positions (b0 = first bit on the wire)
  localparam logic [5:0] BIT_TA      = 6'd46;
  localparam logic [5:0] BIT_TA_LAST = 6'd47;
  localparam logic [5:0] BIT_DATA    = 6'd48;

  // Whole frame, wire bit b sits at vector index 63-b. Read frames carry 1s in
  // the TA/data slots; those bits are never driven because oe is low there.
  function automatic logic [63:0] build_frame(input logic        wr,
                                              input logic [4:0]  phy,
                                              input logic [4:0]  regad,
                                              input logic [15:0] wdata);
    build_frame = {{PRE_BITS{1'b1}}, MDIO_ST,
                   (wr ? MDIO_OP_WR : MDIO_OP_RD), phy, regad,
                   (wr ? MDIO_TA_WR : 2'b11),
                   (wr ? wdata : 16'hFFFF)};
  endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC generator: low for CLK_DIV cycles then high for CLK_DIV cycles while en=1.
// Latency: first rising edge CLK_DIV cycles after en rises; strobes are combinational.
// Backpressure: none; en=0 parks MDC low and clears the divider.
module mdio_mdc_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic rise_stb
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       mdc_q, mdc_d;
  logic       wrap;

  // Strobes mark the cycle at whose end MDC toggles
  assign wrap     = en && (div_q == DIV_LAST);
  assign fall_stb = wrap && mdc_q;
  assign rise_stb = wrap && !mdc_q;
  assign mdc      = mdc_q;

  // Divider and MDC next state; disabled means parked low with divider cleared
  always_comb begin
    div_d = div_q + 8'd1;
    mdc_d = mdc_q;
    if (!en) begin
      div_d = 8'd0;
      mdc_d = 1'b0;
    end else if (wrap) begin
      div_d = 8'd0;
      mdc_d = !mdc_q;
    end
  end

  // Divider and MDC registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q <= 8'd0;
      mdc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/mdio_phy_ctrl.sv
// PHY reset sequencer plus Clause-22 MDIO master, one read/write frame per request.
// Latency: request accepted at T -> rsp_valid at T+1+128*CLK_DIV.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
module mdio_phy_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV  = 25,
  parameter int RST_HOLD = 12500,
  parameter int RST_WAIT = 625000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        phy_reset_req,
  output logic        phy_ready,
  output logic        gmii_rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdio_mdc,
  output logic        mdio_mdd_o,
  output logic        mdio_mdd_oe,
  input  logic        mdio_mdd_i
);

  localparam int             CNT_MAX   = (RST_HOLD > RST_WAIT) ? RST_HOLD : RST_WAIT;
  localparam int             CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT - 1);
  localparam logic [5:0]     LAST_BIT  = 6'(FRAME_BITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        wr_q;
  logic [4:0]  phy_q, reg_q;
  logic [15:0] wdata_q;
  logic [5:0]  bit_q;
  logic [15:0] rdata_q;
  logic        err_q;
  logic        mdd_o_q, mdd_oe_q;
  logic        nxt_o_q, nxt_oe_q;

  logic        accept;
  logic        in_shift;
  logic        last_fall;
  logic        fall_stb, rise_stb;
  logic [63:0] frame;
  logic [5:0]  nxt_bit;

  assign accept    = req_valid && req_ready;
  assign in_shift  = (state_q == SHIFT);
  assign last_fall = in_shift && fall_stb && (bit_q == LAST_BIT);
  assign frame     = build_frame(wr_q, phy_q, reg_q, wdata_q);
  assign nxt_bit   = bit_q + 6'd1;

  mdio_mdc_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_mdc (
    .CLK      (CLK),
    .RST      (RST),
    .en       (in_shift),
    .mdc      (mdio_mdc),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  // FSM state and reset-sequence timer registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= PHY_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the timer restarts on every state change
  always_comb begin
    state_d = state_q;
    case (state_q)
      PHY_RST:  if (cnt_q == HOLD_LAST) state_d = PHY_WAIT;
      PHY_WAIT: if (cnt_q == WAIT_LAST) state_d = IDLE;
      IDLE: begin
        if (phy_reset_req)  state_d = PHY_RST;
        else if (req_valid) state_d = SHIFT;
      end
      SHIFT:    if (last_fall) state_d = RESP;
      RESP:     if (rsp_ready) state_d = IDLE;
      default:  state_d = PHY_RST;
    endcase
    cnt_d = '0;
    if ((state_q == PHY_RST || state_q == PHY_WAIT) && (state_d == state_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Handshake and PHY reset outputs decoded from state
  always_comb begin
    gmii_rstn = (state_q != PHY_RST);
    phy_ready = (state_q == IDLE) || (state_q == SHIFT) || (state_q == RESP);
    req_ready = (state_q == IDLE) && !phy_reset_req;
    rsp_valid = (state_q == RESP);
  end

  // Frame datapath: the next wire bit is looked up at the MDC rise so the
  // 64:1 select has a full half-period, then launched at the MDC fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q     <= 1'b0;
      phy_q    <= 5'd0;
      reg_q    <= 5'd0;
      wdata_q  <= 16'd0;
      bit_q    <= 6'd0;
      rdata_q  <= 16'd0;
      err_q    <= 1'b0;
      mdd_o_q  <= 1'b1;
      mdd_oe_q <= 1'b0;
      nxt_o_q  <= 1'b1;
      nxt_oe_q <= 1'b0;
    end else if (accept) begin
      wr_q     <= req_write;
      phy_q    <= req_phy;
      reg_q    <= req_reg;
      wdata_q  <= req_wdata;
      bit_q    <= 6'd0;
      rdata_q  <= 16'd0;
      err_q    <= 1'b0;
      mdd_o_q  <= 1'b1;
      mdd_oe_q <= 1'b1;
    end else if (in_shift) begin
      if (rise_stb) begin
        if (bit_q == LAST_BIT) begin
          nxt_o_q  <= 1'b1;
          nxt_oe_q <= 1'b0;
        end else begin
          nxt_o_q  <= frame[~nxt_bit];
          nxt_oe_q <= wr_q || (nxt_bit < BIT_TA);
        end
      end
      if (fall_stb) begin
        bit_q    <= nxt_bit;
        mdd_o_q  <= nxt_o_q;
        mdd_oe_q <= nxt_oe_q;
        if (!wr_q && (bit_q == BIT_TA_LAST)) err_q <= mdio_mdd_i;
        if (!wr_q && (bit_q >= BIT_DATA))    rdata_q <= {rdata_q[14:0], mdio_mdd_i};
      end
    end
  end

  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign mdio_mdd_o  = mdd_o_q;
  assign mdio_mdd_oe = mdd_oe_q;

endmodule

// File: tb/tb_mdio_phy_ctrl.sv
// Directed bench for mdio_phy_ctrl with a small MDIO PHY model on the MDC rise.
// Latency: n/a.
// Backpressure: stalls rsp_ready to exercise response hold.
module tb_mdio_phy_ctrl;

  localparam int CLK_DIV  = 2;
  localparam int RST_HOLD = 8;
  localparam int RST_WAIT = 4;
  localparam int LAT      = 1 + 128 * CLK_DIV;
  localparam logic [63:0] RD_OE = 64'hFFFF_FFFF_FFFC_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        phy_reset_req = 1'b0;
  logic        phy_ready, gmii_rstn;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_phy = 5'd0;
  logic [4:0]  req_reg = 5'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mdio_mdc, mdio_mdd_o, mdio_mdd_oe;
  logic        mdio_mdd_i = 1'b1;

  int checks = 0;
  int failures = 0;

  mdio_phy_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .RST_HOLD (RST_HOLD),
    .RST_WAIT (RST_WAIT)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .phy_reset_req (phy_reset_req),
    .phy_ready     (phy_ready),
    .gmii_rstn     (gmii_rstn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_phy       (req_phy),
    .req_reg       (req_reg),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mdio_mdc      (mdio_mdc),
    .mdio_mdd_o    (mdio_mdd_o),
    .mdio_mdd_oe   (mdio_mdd_oe),
    .mdio_mdd_i    (mdio_mdd_i)
  );

  always #5 CLK = ~CLK;

  // Wire capture and PHY model: bit k of the current frame is recorded on its
  // MDC rise; the PHY presents its bit for k at the same moment (mode 1 = present).
  logic        cap_o  [512];
  logic        cap_oe [512];
  int          cap_cnt = 0;
  int          base = 0;
  int          phy_mode = 0;
  logic [15:0] phy_data = 16'h0282;

  always @(posedge mdio_mdc) begin
    int k;
    k = cap_cnt - base;
    cap_o[cap_cnt & 511]  = mdio_mdd_o;
    cap_oe[cap_cnt & 511] = mdio_mdd_oe;
    cap_cnt = cap_cnt + 1;
    if (phy_mode == 1 && k == 47)
      mdio_mdd_i = 1'b0;
    else if (phy_mode == 1 && k >= 48 && k <= 63)
      mdio_mdd_i = phy_data[63 - k];
    else
      mdio_mdd_i = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rst_vals(input string tag);
    check(tag, {56'd0, gmii_rstn, phy_ready, req_ready, rsp_valid, rsp_err,
                mdio_mdc, mdio_mdd_o, mdio_mdd_oe}, 64'b0000_0010);
    check({tag, "_rdata"}, rsp_rdata, 16'h0000);
  endtask

  // Current negedge is cycle 0 of PHY_RST
  task automatic seq_check(input string tag);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge CLK);
      check({tag, "_rstn"}, gmii_rstn, (i >= RST_HOLD) ? 1 : 0);
      check({tag, "_ready"}, {phy_ready, req_ready, rsp_valid},
            (i >= RST_HOLD + RST_WAIT) ? 3'b110 : 3'b000);
    end
  endtask

  // Called after the accept edge; n counts cycles T+1, T+2, ...
  task automatic wait_rsp(input string tag);
    int n;
    n = 1;
    @(negedge CLK);
    while (!rsp_valid && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_latency"}, n, LAT);
  endtask

  task automatic do_req(input logic w, input logic [4:0] p, input logic [4:0] r,
                        input logic [15:0] d, input string tag);
    @(posedge CLK); #1;
    base = cap_cnt;
    req_write = w; req_phy = p; req_reg = r; req_wdata = d; req_valid = 1'b1;
    @(negedge CLK);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    wait_rsp(tag);
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic gather(output logic [63:0] o, output logic [63:0] oe);
    for (int k = 0; k < 64; k++) begin
      o[63 - k]  = cap_o[(base + k) & 511];
      oe[63 - k] = cap_oe[(base + k) & 511];
    end
  endtask

  initial begin
    logic [63:0] got_o, got_oe;
    int snap, hi_cnt;

    // Asynchronous reset values
    #1 RST = 1'b1;
    #1 check_rst_vals("reset");
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    seq_check("por");

    // Write phy=1 reg=0 data=1140
    phy_mode = 0;
    do_req(1'b1, 5'd1, 5'd0, 16'h1140, "wr");
    check("wr_rsp", {rsp_err, rsp_rdata}, 17'h0_0000);
    check("wr_bits", cap_cnt - base, 64);
    gather(got_o, got_oe);
    check("wr_stream", got_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140});
    check("wr_oe", got_oe, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wr_idle_pins", {mdio_mdc, mdio_mdd_oe}, 2'b00);
    accept_rsp();

    // Read phy=1 reg=2 with PHY present
    phy_mode = 1;
    do_req(1'b0, 5'd1, 5'd2, 16'h0000, "rd");
    check("rd_rsp", {rsp_err, rsp_rdata}, {1'b0, 16'h0282});
    gather(got_o, got_oe);
    check("rd_oe", got_oe, RD_OE);
    check("rd_stream", got_o & RD_OE,
          {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2, 18'd0});
    accept_rsp();

    // Read with PHY absent (pull-up), then stall the response
    phy_mode = 0;
    do_req(1'b0, 5'd1, 5'd2, 16'h0000, "rd_abs");
    check("rd_abs_rsp", {rsp_err, rsp_rdata}, {1'b1, 16'hFFFF});
    req_write = 1'b1; req_phy = 5'd3; req_reg = 5'd4; req_wdata = 16'hABCD; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("stall_hold", {rsp_valid, req_ready, mdio_mdc, rsp_err, rsp_rdata},
            {4'b1001, 16'hFFFF});
    end
    rsp_ready = 1'b1;
    check("hs_cycle_req_ready", req_ready, 1'b0);
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    base = cap_cnt;
    @(negedge CLK);
    check("b2b_idle", {req_ready, rsp_valid}, 2'b10);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    wait_rsp("b2b");
    check("b2b_rsp", {rsp_err, rsp_rdata}, 17'h0_0000);
    gather(got_o, got_oe);
    check("b2b_stream", got_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd3, 5'd4, 2'b10, 16'hABCD});
    accept_rsp();

    // PHY reset request in IDLE blocks a simultaneous request
    snap = cap_cnt;
    phy_reset_req = 1'b1; req_valid = 1'b1;
    @(negedge CLK);
    check("rreq_block", {req_ready, phy_ready}, 2'b01);
    @(posedge CLK); #1;
    phy_reset_req = 1'b0; req_valid = 1'b0;
    @(negedge CLK);
    seq_check("rreq");
    check("rreq_no_frame", cap_cnt - snap, 0);

    // Reset in the middle of a write frame (during b40)
    @(posedge CLK); #1;
    base = cap_cnt;
    req_write = 1'b1; req_phy = 5'd5; req_reg = 5'd9; req_wdata = 16'h5555; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 2000 && (cap_cnt - base) < 41; i++) @(negedge CLK);
    check("abort_reach_b40", cap_cnt - base, 41);
    #2 RST = 1'b1;
    #1 check_rst_vals("abort");
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    seq_check("rerun");
    hi_cnt = 0;
    snap = cap_cnt;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (rsp_valid) hi_cnt++;
    end
    check("abort_no_rsp", hi_cnt, 0);
    check("abort_no_mdc", cap_cnt - snap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
